program_sequencer: RTL and testbench
====================================

// Module: program_sequencer
// PURPOSE
// - Program-side counterpart of the ICU: drives the ICU instruction input and consumes its jmp/rtn/flag_f.
// - Holds the program counter and addresses external program memory.
// - Splits each program word into a 4-bit opcode (to the ICU) and an operand (jump target / I/O address).
// - Optional LIFO of return addresses gives JMP-as-call and RTN-as-return.
// PARAMETERS
// - ADDR_W       8  program counter / operand width; program space is 2**ADDR_W words
// - STACK_DEPTH  4  return-stack entries (>=1); only used when the stack is compiled in
// PORTS
// - clk          in   1             system clock; all state updates on the rising edge
// - rst          in   1             asynchronous, active-high reset
// - run          in   1             1 = advance the PC; 0 = hold the PC (stall)
// - prog_addr    out  ADDR_W        program memory address (equals PC)
// - prog_data    in   4+ADDR_W      program word {opcode[3:0], operand[ADDR_W-1:0]}; combinational read
// - instruction  out  instruction_t to ICU: prog_data[ADDR_W+3:ADDR_W]
// - io_addr      out  ADDR_W        I/O select: prog_data[ADDR_W-1:0]
// - jmp          in   1             from ICU: JMP executing this cycle
// - rtn          in   1             from ICU: RTN executing this cycle
// - flag_f       in   1             from ICU: NOPF executing this cycle (marks the next JMP as a call)
// - stack_err    out  1             sticky: overflow or underflow seen (tied 0 without the stack)
// BEHAVIOUR
// - Timing
//   - The ICU latches `instruction` on the falling edge and raises jmp/rtn/flag_f in the second half-cycle.
//   - The sequencer samples them on the next rising edge. The word at PC is still on prog_data at that edge.
//   - So the jump target is the current prog_data operand; no target latch is needed.
// - Reset (async): PC=0, call_pend=0, stack pointer=0, stack_err=0.
//   - Outputs during reset: prog_addr=0, instruction/io_addr follow prog_data at address 0.
// - Each rising edge with run=1, first match wins:
//   - jmp & call_pend (stack built): push PC+1, then PC <= operand.
//   - jmp: PC <= operand.
//   - rtn & stack non-empty (stack built): PC <= pop.
//   - otherwise: PC <= PC+1. Wraps from 2**ADDR_W-1 to 0 with no flag.
// - call_pend
//   - Updates every edge with run=1: call_pend <= flag_f, so it covers exactly the one following instruction.
//   - It is consumed or dropped on the next edge.
// - run=0: PC, call_pend and stack are all frozen; jmp/rtn/flag_f are ignored. Holding `run` low through a jmp loses it.
// - Return address is call-PC+1, but the ICU skips the instruction after RTN.
//   - Programs therefore place a NOPO after each call.
//   - The sequencer does not compensate for the skip.
// - Overflow: push when STACK_DEPTH entries are held.
//   - Push is discarded, the jump still happens, stack_err <= 1.
// - Underflow: rtn with an empty stack.
//   - PC <= PC+1, stack_err <= 1.
// - jmp and rtn in the same cycle cannot come from the ICU; if it happens, jmp wins.
// - stack_err is cleared only by rst.
// CONFIGURATION
// - Macro SEQ_RETURN_STACK_EN
//   - Defined: return stack, call_pend push path, pop on rtn, stack_err logic.
//   - Undefined: no stack storage. jmp is always a plain jump. rtn is treated as PC+1 (the ICU skip still applies). flag_f is ignored. stack_err=0.
// STRUCTURE
// - Package `instructions` (shared with the ICU):
//   - instruction_t (incl. NOPO, NOPF, JMP, RTN).
//   - OPCODE_W=4 constant.
//   - Helper functions word_opcode() / word_operand() used by this block and the program image tools.
// - Sub-module return_stack, instantiated only under SEQ_RETURN_STACK_EN:
//   - Parameters DEPTH and W.
//   - Ports push, pop, din, dout, empty, full.
//   - Async reset of the pointer; no reset of the storage.
// - Top block: PC register, call_pend register, next-PC mux, stack_err.
// TESTING
// - 1. Reset then run=1 with all-NOPO memory -> prog_addr 0,1,2,... and after 256 edges wraps to 0 (ADDR_W=8).
// - 2. jmp pulsed while PC=0x10 with operand 0x40 -> next prog_addr 0x40, stack_err=0.
// - 3. Call and return (stack on):
//   - flag_f at PC=0x05, jmp at PC=0x06 with operand 0x80 -> PC=0x80, depth 1.
//   - Later rtn at PC=0x83 -> PC=0x07.
// - 4. Five nested calls with STACK_DEPTH=4:
//   - Fifth jmp still lands on its target, stack_err=1.
//   - Four rtn pops return the four saved addresses in LIFO order.
// - 5. rtn with empty stack at PC=0x20 -> PC=0x21, stack_err=1. Without the macro: PC=0x21, stack_err=0.
// - 6. Stall and async reset:
//   - run=0 for 3 edges at PC=0x33 -> PC stays 0x33.
//   - rst asserted mid-cycle -> prog_addr=0 immediately, before the next edge.

Source files
------------

// File: rtl/instructions.sv
// Shared instruction definitions for the ICU and the program sequencer.
// A program word is {opcode[OPCODE_W-1:0], operand[addr_w-1:0]}.
package instructions;

    localparam int unsigned OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        NOPO = 4'h0,
        LD   = 4'h1,
        LDC  = 4'h2,
        AND  = 4'h3,
        ANDC = 4'h4,
        OR   = 4'h5,
        ORC  = 4'h6,
        XNOR = 4'h7,
        STO  = 4'h8,
        STOC = 4'h9,
        IEN  = 4'hA,
        OEN  = 4'hB,
        JMP  = 4'hC,
        RTN  = 4'hD,
        SKZ  = 4'hE,
        NOPF = 4'hF
    } instruction_t;

    // Opcode field of a program word whose operand is addr_w bits wide.
    function automatic instruction_t word_opcode(input logic [31:0] word,
                                                 input int unsigned addr_w);
        logic [31:0] shifted;
        shifted = word >> addr_w;
        return instruction_t'(shifted[OPCODE_W-1:0]);
    endfunction

    // Operand field of a program word, zero-extended to 32 bits.
    function automatic logic [31:0] word_operand(input logic [31:0] word,
                                                 input int unsigned addr_w);
        return word & ((32'd1 << addr_w) - 32'd1);
    endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses. Push is ignored when full, pop when empty.
// Only the pointer is reset; the storage is not.
module return_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int unsigned PW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] sp_q, sp_d;
    logic [PW-1:0] top_ptr;
    logic [IW-1:0] wr_idx, rd_idx;

    assign top_ptr = sp_q - PW'(1);
    assign wr_idx  = sp_q[IW-1:0];
    assign rd_idx  = top_ptr[IW-1:0];
    assign empty   = (sp_q == '0);
    assign full    = (sp_q == PW'(DEPTH));
    assign dout    = mem_q[rd_idx];

    // Next stack pointer.
    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q + PW'(1);
        end else if (pop && !empty) begin
            sp_d = top_ptr;
        end
    end

    // Stack pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage write; no reset needed since reads are gated by the pointer.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_idx] <= din;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program counter and program-memory interface for the ICU.
// Optional return stack (JMP after NOPF = call, RTN = return) is enabled
// with the macro SEQ_RETURN_STACK_EN.
module program_sequencer
    import instructions::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    output logic [ADDR_W-1:0]          prog_addr,
    input  logic [OPCODE_W+ADDR_W-1:0] prog_data,
    output instruction_t               instruction,
    output logic [ADDR_W-1:0]          io_addr,
    input  logic                       jmp,
    input  logic                       rtn,
    input  logic                       flag_f,
    output logic                       stack_err
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;

    // The word at PC is still on prog_data when jmp is sampled, so the
    // current operand is the jump target directly.
    assign instruction = word_opcode(32'(prog_data), ADDR_W);
    assign io_addr     = ADDR_W'(word_operand(32'(prog_data), ADDR_W));
    assign prog_addr   = pc_q;
    assign pc_inc      = pc_q + ADDR_W'(1);

`ifdef SEQ_RETURN_STACK_EN
    logic              call_pend_q, call_pend_d;
    logic              err_q, err_d;
    logic              push, pop;
    logic [ADDR_W-1:0] stk_dout;
    logic              stk_empty, stk_full;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_return_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .empty (stk_empty),
        .full  (stk_full)
    );

    // Next-PC mux with call/return handling; jmp has priority over rtn.
    always_comb begin
        pc_d        = pc_q;
        call_pend_d = call_pend_q;
        err_d       = err_q;
        push        = 1'b0;
        pop         = 1'b0;
        if (run) begin
            call_pend_d = flag_f;
            if (jmp) begin
                pc_d = io_addr;
                if (call_pend_q) begin
                    // Overflowing push is dropped but the jump still happens.
                    push = !stk_full;
                    if (stk_full) begin
                        err_d = 1'b1;
                    end
                end
            end else if (rtn) begin
                if (!stk_empty) begin
                    pop  = 1'b1;
                    pc_d = stk_dout;
                end else begin
                    pc_d  = pc_inc;
                    err_d = 1'b1;
                end
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // PC, pending-call and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= '0;
            call_pend_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            call_pend_q <= call_pend_d;
            err_q       <= err_d;
        end
    end

    assign stack_err = err_q;
`else
    logic unused_inputs;

    assign unused_inputs = ^{rtn, flag_f};

    // Next-PC mux: plain jump or increment; rtn just advances.
    always_comb begin
        pc_d = pc_q;
        if (run) begin
            pc_d = jmp ? io_addr : pc_inc;
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign stack_err = 1'b0;
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer (ADDR_W=8, STACK_DEPTH=4).
// Expectations follow SEQ_RETURN_STACK_EN when the macro is defined.
module tb_program_sequencer;
    import instructions::*;

    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         run = 1'b0;
    logic [7:0]   prog_addr;
    logic [11:0]  prog_data;
    instruction_t instruction;
    logic [7:0]   io_addr;
    logic         jmp = 1'b0;
    logic         rtn = 1'b0;
    logic         flag_f = 1'b0;
    logic         stack_err;

    logic [11:0] mem [256];

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [7:0] pc_m;
    bit         cp_m;
    bit         err_m;
    logic [7:0] stk_m [$];

    program_sequencer #(
        .ADDR_W      (8),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .instruction (instruction),
        .io_addr     (io_addr),
        .jmp         (jmp),
        .rtn         (rtn),
        .flag_f      (flag_f),
        .stack_err   (stack_err)
    );

    assign prog_data = mem[prog_addr];

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pc_m  = 8'h00;
        cp_m  = 1'b0;
        err_m = 1'b0;
        stk_m.delete();
    endtask

    // One rising edge of the reference: the spec's priority rules applied directly.
    task automatic model_edge(input bit r, input bit j, input bit t, input bit f,
                              input logic [7:0] op);
        if (!r) return;
`ifdef SEQ_RETURN_STACK_EN
        if (j) begin
            if (cp_m) begin
                if (stk_m.size() < DEPTH) stk_m.push_back(pc_m + 8'd1);
                else err_m = 1'b1;
            end
            pc_m = op;
        end else if (t) begin
            if (stk_m.size() > 0) begin
                pc_m = stk_m.pop_back();
            end else begin
                pc_m  = pc_m + 8'd1;
                err_m = 1'b1;
            end
        end else begin
            pc_m = pc_m + 8'd1;
        end
        cp_m = f;
`else
        pc_m = j ? op : pc_m + 8'd1;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_pc", 32'(prog_addr), 32'h0);
        check("rst_err", 32'(stack_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input bit r, input bit j, input bit t, input bit f);
        logic [7:0] op;
        @(negedge clk);
        run = r; jmp = j; rtn = t; flag_f = f;
        #1;
        check("instr", 32'(instruction), 32'(mem[pc_m][11:8]));
        check("io_addr", 32'(io_addr), 32'(mem[pc_m][7:0]));
        op = mem[pc_m][7:0];
        @(posedge clk);
        #1;
        model_edge(r, j, t, f, op);
        run = 1'b0; jmp = 1'b0; rtn = 1'b0; flag_f = 1'b0;
        check("pc", 32'(prog_addr), 32'(pc_m));
        check("err", 32'(stack_err), 32'(err_m));
    endtask

    task automatic goto(input logic [7:0] addr);
        mem[pc_m] = {4'hC, addr};
        step(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 12'h000;
    endtask

    logic [7:0] ret_exp [4];

    initial begin
        clear_mem();
        model_reset();

        // 1: free run over NOPO memory wraps after 256 edges.
        do_reset();
        for (int i = 0; i < 256; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_wrap", 32'(prog_addr), 32'h0);

        // 2: plain jump.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        mem[8'h10] = {4'hC, 8'h40};
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t2_pc", 32'(prog_addr), 32'h40);
        check("t2_err", 32'(stack_err), 32'h0);

        // 3: call and return.
        do_reset();
        clear_mem();
        goto(8'h05);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        mem[8'h06] = {4'hC, 8'h80};
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t3_call", 32'(prog_addr), 32'h80);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
`ifdef SEQ_RETURN_STACK_EN
        check("t3_ret", 32'(prog_addr), 32'h07);
`else
        check("t3_ret", 32'(prog_addr), 32'h84);
`endif

        // 5: rtn with empty stack.
        do_reset();
        goto(8'h20);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("t5_pc", 32'(prog_addr), 32'h21);
`ifdef SEQ_RETURN_STACK_EN
        check("t5_err", 32'(stack_err), 32'h1);
`else
        check("t5_err", 32'(stack_err), 32'h0);
`endif

        // 4: five nested calls into a four-entry stack.
        do_reset();
        clear_mem();
        goto(8'h40);
        ret_exp[0] = 8'h42; ret_exp[1] = 8'h92; ret_exp[2] = 8'hA2; ret_exp[3] = 8'hB2;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1);
            mem[pc_m] = {4'hC, 8'(8'h90 + 8'(i * 16))};
            step(1'b1, 1'b1, 1'b0, 1'b0);
        end
        check("t4_target", 32'(prog_addr), 32'hD0);
`ifdef SEQ_RETURN_STACK_EN
        check("t4_err", 32'(stack_err), 32'h1);
`endif
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
`ifdef SEQ_RETURN_STACK_EN
            check("t4_pop", 32'(prog_addr), 32'(ret_exp[3-k]));
`endif
        end
        step(1'b1, 1'b0, 1'b1, 1'b0);

        // 6: stall then asynchronous reset.
        do_reset();
        goto(8'h33);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        check("t6_stall", 32'(prog_addr), 32'h33);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("t6_resume", 32'(prog_addr), 32'h34);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_rst", 32'(prog_addr), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Random programs and control traffic against the model.
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 8) != 0, ($urandom % 6) == 0, ($urandom % 6) == 0,
                 ($urandom % 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
